// File: rtl/lcd_responder.sv
// Device-side HD44780-style LCD bus responder: synchronises E/RS/RW/data, keeps DDRAM, AC and busy flag.
// Optional read path (status/data reads) is built only when LCD_RESPONDER_READ_EN is defined.
//
// state | meaning
// IDLE  | not busy, writes accepted
// BUSY  | down-counter running, writes rejected as overrun
// CLEAR | filling DDRAM with 0x20, counter running, then BUSY
module lcd_responder #(
  parameter int BUSY_CYCLES  = 37,
  parameter int CLEAR_CYCLES = 152
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_E,
  input  logic       i_RS,
  input  logic       i_RW,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_data_oe,
  output logic       o_busy,
  output logic [6:0] o_ac,
  output logic       o_overrun,
  input  logic [6:0] i_dbg_addr,
  output logic [7:0] o_dbg_char
);

  typedef enum logic [1:0] {IDLE, BUSY, CLEAR} state_t;

  localparam logic [15:0] BUSY_LOAD  = 16'(BUSY_CYCLES - 1);
  localparam logic [15:0] CLEAR_LOAD = 16'(CLEAR_CYCLES - 1);

  state_t      state, state_nx;
  logic        e_s1, e_s2, e_q;
  logic        rs_s1, rs_s2, rw_s1, rw_s2;
  logic [7:0]  d_s1, d_s2;
  logic        strobe;
  logic [15:0] cnt, cnt_nx;
  logic [6:0]  ac, ac_nx, ac_step;
  logic [6:0]  fill, fill_nx;
  logic        id, id_nx;
  logic        overrun_nx;
  logic        busy;
  logic [7:0]  ram [128];
  logic        ram_we;
  logic [6:0]  ram_addr;
  logic [7:0]  ram_wdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      e_s1  <= 1'b0;
      e_s2  <= 1'b0;
      e_q   <= 1'b0;
      rs_s1 <= 1'b0;
      rs_s2 <= 1'b0;
      rw_s1 <= 1'b0;
      rw_s2 <= 1'b0;
      d_s1  <= 8'h00;
      d_s2  <= 8'h00;
    end else begin
      e_s1  <= i_E;
      e_s2  <= e_s1;
      e_q   <= e_s2;
      rs_s1 <= i_RS;
      rs_s2 <= rs_s1;
      rw_s1 <= i_RW;
      rw_s2 <= rw_s1;
      d_s1  <= i_data;
      d_s2  <= d_s1;
    end
  end

  assign strobe  = e_q & ~e_s2;
  assign busy    = (state != IDLE);
  assign ac_step = id ? ac + 7'd1 : ac - 7'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      ac        <= 7'd0;
      id        <= 1'b1;
      fill      <= 7'd0;
      o_overrun <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      ac        <= ac_nx;
      id        <= id_nx;
      fill      <= fill_nx;
      o_overrun <= overrun_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    ac_nx      = ac;
    id_nx      = id;
    fill_nx    = fill;
    overrun_nx = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = ac;
    ram_wdata  = d_s2;

    // One counter spans the whole clear, so the fill is included in CLEAR_CYCLES.
    case (state)
      BUSY: begin
        if (cnt == 16'd0) state_nx = IDLE;
        else              cnt_nx   = cnt - 16'd1;
      end
      CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = fill;
        ram_wdata = 8'h20;
        fill_nx   = fill + 7'd1;
        if (cnt == 16'd0) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 16'd1;
          if (fill == 7'd127) state_nx = BUSY;
        end
      end
      default: ;
    endcase

    if (strobe && !rw_s2) begin
      if (busy) begin
        overrun_nx = 1'b1;
      end else if (rs_s2) begin
        ram_we    = 1'b1;
        ram_addr  = ac;
        ram_wdata = d_s2;
        ac_nx     = ac_step;
        state_nx  = BUSY;
        cnt_nx    = BUSY_LOAD;
      end else begin
        state_nx = BUSY;
        cnt_nx   = BUSY_LOAD;
        if (d_s2 == 8'h01) begin
          ac_nx    = 7'd0;
          id_nx    = 1'b1;
          fill_nx  = 7'd0;
          state_nx = CLEAR;
          cnt_nx   = CLEAR_LOAD;
        end else if (d_s2[7:1] == 7'h01) begin
          ac_nx  = 7'd0;
          cnt_nx = CLEAR_LOAD;
        end else if (d_s2[7:2] == 6'h01) begin
          id_nx = d_s2[1];
        end else if (d_s2[7]) begin
          ac_nx = d_s2[6:0];
        end
      end
    end
`ifdef LCD_RESPONDER_READ_EN
    else if (strobe && rs_s2) begin
      ac_nx = ac_step;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_dbg_char <= 8'h00;
    else          o_dbg_char <= ram[i_dbg_addr];
  end

`ifdef LCD_RESPONDER_READ_EN
  logic rd_active;
  assign rd_active = e_s2 & rw_s2;
  assign o_data_oe = rd_active;
  assign o_data    = !rd_active ? 8'h00 : (rs_s2 ? ram[ac] : {busy, ac});
`else
  assign o_data_oe = 1'b0;
  assign o_data    = 8'h00;
`endif

  assign o_busy = busy;
  assign o_ac   = ac;

endmodule

// File: tb/tb_lcd_responder.sv
// Bench for lcd_responder: directed and random bus cycles checked cycle by cycle against a behavioural LCD model.
module tb_lcd_responder;

  localparam int BUSY_N  = 37;
  localparam int CLEAR_N = 152;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       e_bus = 1'b0;
  logic       rs_bus = 1'b0;
  logic       rw_bus = 1'b0;
  logic [7:0] din = 8'h00;
  logic [6:0] dbg_addr = 7'd0;
  logic [7:0] o_data;
  logic       o_data_oe;
  logic       o_busy;
  logic [6:0] o_ac;
  logic       o_overrun;
  logic [7:0] o_dbg_char;

  lcd_responder #(.BUSY_CYCLES(BUSY_N), .CLEAR_CYCLES(CLEAR_N)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_E(e_bus), .i_RS(rs_bus), .i_RW(rw_bus),
    .i_data(din), .o_data(o_data), .o_data_oe(o_data_oe), .o_busy(o_busy),
    .o_ac(o_ac), .o_overrun(o_overrun), .i_dbg_addr(dbg_addr), .o_dbg_char(o_dbg_char)
  );

  always #5 clk = ~clk;

  // Behavioural model: display memory, address counter, direction, remaining busy samples.
  logic [7:0] mem [128];
  logic [7:0] mem_save [128];
  bit         valid [128];
  logic [6:0] ac_m;
  bit         id_m;
  int         busy_left;
  bit         last_busy;
  bit         exp_ov;
  int         n_assert = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit exp_b;
    @(negedge clk);
    exp_b = (busy_left > 0);
    check("busy", 32'(o_busy), 32'(exp_b));
    check("overrun", 32'(o_overrun), 32'(exp_ov));
    check("ac", 32'(o_ac), 32'(ac_m));
    exp_ov    = 1'b0;
    last_busy = exp_b;
    if (busy_left > 0) busy_left--;
  endtask

  task automatic model_strobe(input bit rs, input bit rw, input logic [7:0] d);
    if (rw) begin
`ifdef LCD_RESPONDER_READ_EN
      if (rs) ac_m = id_m ? ac_m + 7'd1 : ac_m - 7'd1;
`endif
    end else if (last_busy) begin
      exp_ov = 1'b1;
    end else begin
      busy_left = BUSY_N;
      if (rs) begin
        mem[ac_m]   = d;
        valid[ac_m] = 1'b1;
        ac_m = id_m ? ac_m + 7'd1 : ac_m - 7'd1;
      end else if (d == 8'h01) begin
        for (int i = 0; i < 128; i++) begin
          mem[i]   = 8'h20;
          valid[i] = 1'b1;
        end
        ac_m = 7'd0;
        id_m = 1'b1;
        busy_left = CLEAR_N;
      end else if (d == 8'h02 || d == 8'h03) begin
        ac_m = 7'd0;
        busy_left = CLEAR_N;
      end else if (d >= 8'h04 && d <= 8'h07) begin
        id_m = d[1];
      end else if (d >= 8'h80) begin
        ac_m = d[6:0];
      end
    end
  endtask

  task automatic rd_check(input bit rs, input bit rw);
`ifdef LCD_RESPONDER_READ_EN
    if (rw) begin
      check("read_oe", 32'(o_data_oe), 32'd1);
      if (!rs)                check("status_read", 32'(o_data), 32'({last_busy, ac_m}));
      else if (valid[ac_m])   check("data_read", 32'(o_data), 32'(mem[ac_m]));
    end else begin
      check("write_oe", 32'(o_data_oe), 32'd0);
    end
`else
    check("oe_off", 32'(o_data_oe), 32'd0);
    check("data_off", 32'(o_data), 32'd0);
`endif
  endtask

  task automatic bus(input bit rs, input bit rw, input logic [7:0] d);
    rs_bus = rs;
    rw_bus = rw;
    din    = d;
    e_bus  = 1'b1;
    tick();
    tick();
    rd_check(rs, rw);
    tick();
    rd_check(rs, rw);
    e_bus = 1'b0;
    tick();
    tick();
    model_strobe(rs, rw, d);
    tick();
    check("oe_after", 32'(o_data_oe), 32'd0);
  endtask

  task automatic wait_idle();
    while (busy_left > 0) tick();
  endtask

  task automatic dbg_check(input logic [6:0] a);
    dbg_addr = a;
    tick();
    if (valid[a]) check("dbg_char", 32'(o_dbg_char), 32'(mem[a]));
  endtask

  initial begin
    int op;
    ac_m = 7'd0; id_m = 1'b1; busy_left = 0; last_busy = 1'b0; exp_ov = 1'b0;
    for (int i = 0; i < 128; i++) begin
      valid[i] = 1'b0;
      mem[i]   = 8'h00;
    end

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_ac", 32'(o_ac), 32'd0);
    check("rst_overrun", 32'(o_overrun), 32'd0);
    check("rst_dbg", 32'(o_dbg_char), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_oe", 32'(o_data_oe), 32'd0);
    rst_n = 1'b1;
    tick();

    bus(0, 0, 8'h80); wait_idle();
    bus(1, 0, 8'h41); wait_idle();
    bus(1, 0, 8'h42); wait_idle();
    dbg_check(7'd0);
    dbg_check(7'd1);
    check("ac_after_two", 32'(o_ac), 32'd2);

    bus(0, 0, 8'h01); wait_idle();
    for (int i = 0; i < 128; i++) dbg_check(7'(i));

    bus(0, 0, 8'h04); wait_idle();
    bus(0, 0, 8'h80); wait_idle();
    bus(1, 0, 8'h55);
    bus(1, 0, 8'h33);
`ifdef LCD_RESPONDER_READ_EN
    bus(0, 1, 8'h00);
`endif
    wait_idle();
    check("ac_wrap_down", 32'(o_ac), 32'd127);
    dbg_check(7'd0);
    dbg_check(7'd127);

    bus(0, 0, 8'h06); wait_idle();
    bus(0, 0, 8'hFF); wait_idle();
    bus(1, 0, 8'h21); wait_idle();
    check("ac_wrap_up", 32'(o_ac), 32'd0);
    dbg_check(7'd127);

    bus(0, 0, 8'h90); wait_idle();
    bus(1, 0, 8'h7A); wait_idle();
    bus(0, 0, 8'h90);
    bus(0, 1, 8'h00);
    bus(1, 1, 8'h00);
`ifdef LCD_RESPONDER_READ_EN
    check("ac_after_read", 32'(o_ac), 32'h11);
`endif
    wait_idle();

    // Strobe landing on the last busy cycle is an overrun; one cycle later it is accepted.
    bus(0, 0, 8'h08);
    while (busy_left > 5) tick();
    bus(1, 0, 8'h66);
    wait_idle();
    bus(0, 0, 8'h08);
    while (busy_left > 4) tick();
    bus(1, 0, 8'h67);
    wait_idle();

    for (int it = 0; it < 60; it++) begin
      op = int'($urandom_range(0, 9));
      case (op)
        0, 1, 2: bus(1, 0, 8'($urandom_range(0, 255)));
        3:       bus(0, 0, 8'h80 | 8'($urandom_range(0, 127)));
        4:       bus(0, 0, 8'(4 + $urandom_range(0, 3)));
        5:       bus(0, 0, 8'(2 + $urandom_range(0, 1)));
        6:       bus(0, 0, 8'($urandom_range(8, 127)));
        7:       bus(1, 1, 8'h00);
        8:       bus(0, 1, 8'h00);
        default: bus(0, 0, ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00);
      endcase
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 10)) tick();
      else wait_idle();
    end
    wait_idle();
    for (int i = 0; i < 128; i += 3) dbg_check(7'(i));

    // Reset in the middle of a clear fill.
    mem_save = mem;
    bus(0, 0, 8'h01);
    repeat (50) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(o_busy), 32'd0);
    check("async_rst_ac", 32'(o_ac), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem = mem_save;
    for (int i = 0; i < 40; i++) mem[i] = 8'h20;
    for (int i = 40; i < 60; i++) valid[i] = 1'b0;
    ac_m = 7'd0; id_m = 1'b1; busy_left = 0; last_busy = 1'b0; exp_ov = 1'b0;
    tick();
    bus(0, 0, 8'h85); wait_idle();
    bus(1, 0, 8'hC3); wait_idle();
    for (int i = 0; i < 128; i += 5) dbg_check(7'(i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
